// File: rtl/reg_file_64.sv
// reg_file_64: 32 x 64-bit RISC-V integer register file with 2R/1W ports
// and a per-register busy scoreboard for RAW hazard stalls.
// Ports: clk, rst_n (async, active-low); rs1/rs2 addr -> data/busy reads;
// issue_valid/issue_rd mark a pending producer; wb_valid/wb_rd/wb_data
// write back; stall = rs1_busy | rs2_busy | (issue_valid & busy[issue_rd]).
// Optional macro WRITE_BYPASS_EN: same-cycle writeback forwards to reads
// and masks rsN_busy for the register being written.
module reg_file_64 #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_rs1_busy;
    logic            w_rs2_busy;
    logic            w_stall;
    logic            w_wb_en;
    logic            w_issue_en;
    logic [NREG-1:0] w_busy_nxt;

    assign w_wb_en = wb_valid && (wb_rd != '0);

    always_comb begin
        w_rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
        w_rs2_data = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
        w_rs1_busy = r_busy[rs1_addr];
        w_rs2_busy = r_busy[rs2_addr];
`ifdef WRITE_BYPASS_EN
        if (w_wb_en && (wb_rd == rs1_addr)) begin
            w_rs1_data = wb_data;
        end
        if (w_wb_en && (wb_rd == rs2_addr)) begin
            w_rs2_data = wb_data;
        end
        // The value arrives this cycle, so the consumer need not wait.
        if (wb_valid && (wb_rd == rs1_addr)) begin
            w_rs1_busy = 1'b0;
        end
        if (wb_valid && (wb_rd == rs2_addr)) begin
            w_rs2_busy = 1'b0;
        end
`endif
    end

    assign w_stall = w_rs1_busy || w_rs2_busy ||
                     (issue_valid && r_busy[issue_rd]);

    assign w_issue_en = issue_valid && (issue_rd != '0) && !w_stall;

    // Clear first, then set: a newly issued producer outranks the
    // older writeback to the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_en) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_issue_en) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wb_en) begin
                r_regs[wb_rd] <= wb_data;
            end
            r_busy <= {w_busy_nxt[NREG-1:1], 1'b0};
        end
    end

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;
    assign rs1_busy = w_rs1_busy;
    assign rs2_busy = w_rs2_busy;
    assign stall    = w_stall;

endmodule

// File: tb/tb_reg_file_64.sv
// tb_reg_file_64: directed self-checking bench for reg_file_64.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_reg_file_64;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall;

    int n_vec;
    int n_err;

    reg_file_64 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            n_vec++;
            if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
                n_err++;
                $display("FAIL reset_data idx=%0d got %h/%h want 0",
                         i, rs1_data, rs2_data);
            end
            n_vec++;
            if ({rs1_busy, rs2_busy, stall} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_busy idx=%0d got %b want 000",
                         i, {rs1_busy, rs2_busy, stall});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        idle();
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        #1;
        n_vec++;
        if (rs1_data !== 64'hDEADBEEF_CAFEF00D) begin
            n_err++;
            $display("FAIL wr_x5 got %h want deadbeefcafef00d", rs1_data);
        end
        n_vec++;
        if (rs2_data !== 64'd0) begin
            n_err++;
            $display("FAIL rd_x0 got %h want 0", rs2_data);
        end
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        wb_data  = '1;
        @(negedge clk);
        idle();
        rs1_addr = 5'd0;
        rs2_addr = 5'd5;
        #1;
        n_vec++;
        if (rs1_data !== 64'd0) begin
            n_err++;
            $display("FAIL wr_x0 got %h want 0", rs1_data);
        end
        n_vec++;
        if (rs2_data !== 64'hDEADBEEF_CAFEF00D) begin
            n_err++;
            $display("FAIL x5_kept got %h want deadbeefcafef00d", rs2_data);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL issue7_nostall got %b want 0", stall);
        end
        @(negedge clk);
        rs2_addr = 5'd7;
        #1;
        n_vec++;
        if (rs2_busy !== 1'b1 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL busy7 got busy=%b stall=%b want 1/1",
                     rs2_busy, stall);
        end
        @(negedge clk);
        issue_rd = 5'd8;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold got %b want 1", stall);
        end
        @(negedge clk);
        idle();
        rs1_addr = 5'd8;
        #1;
        n_vec++;
        if (rs1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL stalled_issue8 got busy=%b want 0", rs1_busy);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = 64'h1234;
        @(negedge clk);
        idle();
        rs2_addr = 5'd7;
        #1;
        n_vec++;
        if (rs2_busy !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL wb7_clear got busy=%b stall=%b want 0/0",
                     rs2_busy, stall);
        end
        n_vec++;
        if (rs2_data !== 64'h1234) begin
            n_err++;
            $display("FAIL wb7_data got %h want 1234", rs2_data);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        wb_valid    = 1'b1;
        wb_rd       = 5'd9;
        wb_data     = 64'h9999_0000_0000_0009;
        @(negedge clk);
        idle();
        rs1_addr = 5'd9;
        #1;
        n_vec++;
        if (rs1_busy !== 1'b1) begin
            n_err++;
            $display("FAIL setwins_busy9 got %b want 1", rs1_busy);
        end
        n_vec++;
        if (rs1_data !== 64'h9999_0000_0000_0009) begin
            n_err++;
            $display("FAIL setwins_x9 got %h want 9999000000000009",
                     rs1_data);
        end
        issue_valid = 1'b1;
        issue_rd    = 5'd10;
        wb_valid    = 1'b1;
        wb_rd       = 5'd9;
        wb_data     = 64'h42;
        rs1_addr    = 5'd0;
        @(negedge clk);
        idle();
        rs1_addr = 5'd9;
        rs2_addr = 5'd10;
        #1;
        n_vec++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1) begin
            n_err++;
            $display("FAIL diff_idx got b9=%b b10=%b want 0/1",
                     rs1_busy, rs2_busy);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd10;
        wb_data  = 64'h10;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        @(negedge clk);
        idle();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        wb_valid    = 1'b1;
        wb_rd       = 5'd3;
        wb_data     = 64'h1111;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        @(negedge clk);
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 64'hA5A5;
        rs1_addr = 5'd3;
        #1;
`ifdef WRITE_BYPASS_EN
        n_vec++;
        if (rs1_data !== 64'hA5A5 || rs1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL bypass got %h busy=%b want a5a5/0",
                     rs1_data, rs1_busy);
        end
`else
        n_vec++;
        if (rs1_data !== 64'h1111 || rs1_busy !== 1'b1) begin
            n_err++;
            $display("FAIL nobypass got %h busy=%b want 1111/1",
                     rs1_data, rs1_busy);
        end
`endif
        @(negedge clk);
        idle();
        rs1_addr = 5'd3;
        #1;
        n_vec++;
        if (rs1_data !== 64'hA5A5 || rs1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL after_wb3 got %h busy=%b want a5a5/0",
                     rs1_data, rs1_busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        @(negedge clk);
        idle();
        rs1_addr = 5'd4;
        rs2_addr = 5'd5;
        #1;
        n_vec++;
        if (rs1_busy !== 1'b1 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL pre_rst busy4=%b stall=%b want 1/1",
                     rs1_busy, stall);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rs1_busy !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst busy4=%b stall=%b want 0/0",
                     rs1_busy, stall);
        end
        n_vec++;
        if (rs2_data !== 64'd0) begin
            n_err++;
            $display("FAIL async_rst_x5 got %h want 0", rs2_data);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        wb_data  = 64'h6666;
        @(negedge clk);
        idle();
        rst_n    = 1'b1;
        rs1_addr = 5'd4;
        rs2_addr = 5'd6;
        #1;
        n_vec++;
        if (stall !== 1'b0 || rs1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst stall=%b busy4=%b want 0/0",
                     stall, rs1_busy);
        end
        n_vec++;
        if (rs2_data !== 64'd0) begin
            n_err++;
            $display("FAIL wb_in_rst x6 got %h want 0", rs2_data);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_cycle();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
